// File: rtl/ram_table_loader.sv
// ram_table_loader: clears a hash-table RAM after reset or clear_req, then
// streams (address, data) config beats into its single registered write port.
// Reports busy/done, a committed-write count and a sticky out-of-range error.
module ram_table_loader #(
  parameter int                 DWIDTH      = 16,
  parameter int                 AWIDTH      = 15,
  parameter int                 MEM_SIZE    = 32768,
  parameter logic [DWIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_addr,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH:0]   wr_count,
  output logic              err_oob
);

  // Pointer is one bit wider than the address so MEM_SIZE == 2^AWIDTH
  // can be reached as the terminal value without wrapping.
  localparam logic [AWIDTH:0] L_MEM_SIZE = (AWIDTH+1)'(MEM_SIZE);
  localparam logic [AWIDTH:0] L_ONE      = (AWIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH:0]     r_ptr;
  logic                r_wr_en;
  logic [AWIDTH-1:0]   r_wr_addr;
  logic [DWIDTH-1:0]   r_wr_data;
  logic [AWIDTH:0]     r_wr_count;
  logic                r_err_oob;

  logic                w_accept;
  logic                w_in_range;
  logic                w_sweep_end;

  // clear_req overrides the handshake, so a beat in that cycle is dropped.
  assign w_accept    = in_valid && (r_state == S_LOAD) && !clear_req;
  assign w_in_range  = ({1'b0, in_addr} < L_MEM_SIZE);
  assign w_sweep_end = (r_ptr == L_MEM_SIZE);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_CLEAR;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; CLEAR leaves only once the pointer has passed the last entry.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_req) begin
      w_state_nxt = S_CLEAR;
    end else begin
      case (r_state)
        S_CLEAR: if (w_sweep_end)          w_state_nxt = S_LOAD;
        S_LOAD:  if (w_accept && in_last)  w_state_nxt = S_DONE;
        S_DONE:                            w_state_nxt = S_DONE;
        default:                           w_state_nxt = S_CLEAR;
      endcase
    end
  end

  // Write port, sweep pointer, count and error flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_count <= '0;
      r_err_oob  <= 1'b0;
    end else if (clear_req) begin
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_count <= '0;
      r_err_oob  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (!w_sweep_end) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_ptr[AWIDTH-1:0];
            r_wr_data <= CLEAR_VALUE;
            r_ptr     <= r_ptr + L_ONE;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_in_range) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= in_addr;
              r_wr_data <= in_data;
              if (r_wr_count != '1) r_wr_count <= r_wr_count + L_ONE;
            end else begin
              r_err_oob <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (r_state == S_LOAD);
  assign busy     = (r_state == S_CLEAR);
  assign done     = (r_state == S_DONE);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_count = r_wr_count;
  assign err_oob  = r_err_oob;

endmodule

// File: tb/tb_ram_table_loader.sv
// Bench for ram_table_loader: expected RAM writes go into a queue when the
// stimulus is driven; a negedge monitor pops and compares every wr_en cycle.
module tb_ram_table_loader;

  localparam int              DW  = 8;
  localparam int              AW  = 5;
  localparam int              MS  = 16;
  localparam logic [DW-1:0]   CLR = 8'hA5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          clear_req;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic          err_oob;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW+DW-1:0] exp_q[$];

  ram_table_loader #(
    .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .CLEAR_VALUE(CLR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_last(in_last), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .wr_count(wr_count), .err_oob(err_oob)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every write on the port must match the oldest expected write.
  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
      else                   chk("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Full clear sweep starting at the next edge; LOAD follows one edge after the last write.
  task automatic sweep(input string tag);
    for (int i = 0; i < MS; i++) push_wr(AW'(i), CLR);
    for (int i = 0; i < MS; i++) begin
      tick();
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_wren"}, 32'(wr_en), 32'd1);
      chk({tag, "_addr"}, 32'(wr_addr), 32'(i));
    end
    tick();
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_wren_end"}, 32'(wr_en), 32'd0);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Present one beat and advance past the edge that samples it.
  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_last  = last;
    if ({1'b0, a} < (AW+1)'(MS)) push_wr(a, d);
    tick();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
    chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
    chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_count"},    32'(wr_count), 32'd0);
    chk({tag, "_err"},      32'(err_oob),  32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd1);
  endtask

  initial begin
    reset_n = 1'b0; clear_req = 1'b0; in_valid = 1'b0;
    in_addr = '0; in_data = '0; in_last = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");

    // Clear sweep after reset release.
    reset_n = 1'b1;
    sweep("sweep0");

    // Back-to-back load, duplicate address 3 written twice in order.
    beat(5'd3, 8'h11, 1'b0);
    beat(5'd7, 8'h22, 1'b0);
    beat(5'd3, 8'h33, 1'b1);
    idle_inputs();
    chk("b2b_done",  32'(done),     32'd1);
    chk("b2b_ready", 32'(in_ready), 32'd0);
    chk("b2b_count", 32'(wr_count), 32'd3);
    chk("b2b_addr",  32'(wr_addr),  32'd3);
    chk("b2b_data",  32'(wr_data),  32'h33);
    tick();
    chk("done_hold", 32'(done), 32'd1);
    chk("done_nowr", 32'(wr_en), 32'd0);

    // clear_req in DONE, with a beat presented in the same cycle.
    clear_req = 1'b1; in_valid = 1'b1; in_addr = 5'd9; in_data = 8'h77;
    tick();
    clear_req = 1'b0; idle_inputs();
    chk("clr_done",  32'(done),     32'd0);
    chk("clr_busy",  32'(busy),     32'd1);
    chk("clr_count", 32'(wr_count), 32'd0);
    chk("clr_err",   32'(err_oob),  32'd0);
    chk("clr_wren",  32'(wr_en),    32'd0);
    sweep("sweep1");

    // clear_req overrides a handshake in LOAD.
    clear_req = 1'b1; in_valid = 1'b1; in_addr = 5'd2; in_data = 8'h44;
    tick();
    clear_req = 1'b0; idle_inputs();
    chk("ovr_wren",  32'(wr_en),    32'd0);
    chk("ovr_busy",  32'(busy),     32'd1);
    chk("ovr_count", 32'(wr_count), 32'd0);
    sweep("sweep2");

    // Handshake stall: valid 1,0,1 gives two writes and no write in the gap.
    beat(5'd1, 8'h55, 1'b0);
    idle_inputs();
    chk("stall_w1", 32'(wr_en), 32'd1);
    tick();
    chk("stall_gap", 32'(wr_en), 32'd0);
    beat(5'd2, 8'h66, 1'b0);
    idle_inputs();
    chk("stall_w2",    32'(wr_en),    32'd1);
    chk("stall_count", 32'(wr_count), 32'd2);
    tick();

    // Out-of-range beat, then an in-range last beat.
    beat(5'd20, 8'h99, 1'b0);
    idle_inputs();
    chk("oob_wren",  32'(wr_en),    32'd0);
    chk("oob_err",   32'(err_oob),  32'd1);
    chk("oob_count", 32'(wr_count), 32'd2);
    beat(5'd5, 8'hAB, 1'b1);
    idle_inputs();
    chk("oob2_done",  32'(done),     32'd1);
    chk("oob2_err",   32'(err_oob),  32'd1);
    chk("oob2_count", 32'(wr_count), 32'd3);
    chk("oob2_addr",  32'(wr_addr),  32'd5);
    tick();

    // Reset in the middle of a load.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    sweep("sweep3");
    beat(5'd4, 8'h12, 1'b0);
    beat(5'd6, 8'h34, 1'b0);
    idle_inputs();
    chk("mid_count", 32'(wr_count), 32'd2);
    reset_n = 1'b0;
    tick();
    chk_reset_vals("mid_rst");
    reset_n = 1'b1;
    sweep("sweep4");

    tick();
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
